// File: rtl/adma_atx_arb_pipe.sv
`default_nettype none
// ============================================================================
// Module  : adma_atx_arb_pipe
// Brief   : N-channel AR/AW descriptor arbiter (WRR or fixed priority) with a
//           registered, back-pressure-safe output slot.
// Revision: 1.0
// ============================================================================
module adma_atx_arb_pipe #(
    parameter int DMA_CHN_NUM   = 4,
    parameter int DMA_CHN_ARB_W = 3,
    parameter int SRC_ADDR_W    = 32,
    parameter int DST_ADDR_W    = 32,
    parameter int MST_ID_W      = 5,
    parameter int ATX_LEN_W     = 8,
    localparam int DMA_CHN_NUM_W = $clog2(DMA_CHN_NUM)
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic [DMA_CHN_NUM*MST_ID_W-1:0]     bwd_arid,
    input  logic [DMA_CHN_NUM*SRC_ADDR_W-1:0]   bwd_araddr,
    input  logic [DMA_CHN_NUM*ATX_LEN_W-1:0]    bwd_arlen,
    input  logic [DMA_CHN_NUM*2-1:0]            bwd_arburst,
    input  logic [DMA_CHN_NUM*MST_ID_W-1:0]     bwd_awid,
    input  logic [DMA_CHN_NUM*DST_ADDR_W-1:0]   bwd_awaddr,
    input  logic [DMA_CHN_NUM*ATX_LEN_W-1:0]    bwd_awlen,
    input  logic [DMA_CHN_NUM*2-1:0]            bwd_awburst,
    input  logic [DMA_CHN_NUM-1:0]              bwd_atx_vld,
    output logic [DMA_CHN_NUM-1:0]              bwd_atx_rdy,
    input  logic [DMA_CHN_NUM-1:0]              chn_en,
    input  logic [DMA_CHN_NUM*DMA_CHN_ARB_W-1:0] chn_arb_rate,
    input  logic                                arb_mode,
    output logic [DMA_CHN_NUM_W-1:0]            fwd_atx_chn_id,
    output logic [MST_ID_W-1:0]                 fwd_arid,
    output logic [SRC_ADDR_W-1:0]               fwd_araddr,
    output logic [ATX_LEN_W-1:0]                fwd_arlen,
    output logic [1:0]                          fwd_arburst,
    output logic [MST_ID_W-1:0]                 fwd_awid,
    output logic [DST_ADDR_W-1:0]               fwd_awaddr,
    output logic [ATX_LEN_W-1:0]                fwd_awlen,
    output logic [1:0]                          fwd_awburst,
    output logic                                fwd_atx_vld,
    input  logic                                fwd_atx_rdy
);

    localparam int CW = DMA_CHN_NUM_W;
    localparam int RW = DMA_CHN_ARB_W;
    localparam logic [CW:0]   C_CHN_NUM  = (CW+1)'(DMA_CHN_NUM);
    localparam logic [CW-1:0] C_LAST_CHN = CW'(DMA_CHN_NUM - 1);
    localparam logic [RW-1:0] C_ONE      = RW'(1);

    logic [DMA_CHN_NUM-1:0] elig;
    logic                   win_vld;
    logic [CW-1:0]          win_idx;
    logic [CW:0]            scan_idx;
    logic                   slot_free;
    logic                   capture;
    logic [RW-1:0]          rate_ptr, rate_win, ecred;

    logic [CW-1:0]          ptr_d, ptr_q;
    logic [RW-1:0]          cred_d, cred_q;
    logic                   vld_d, vld_q;
    logic [CW-1:0]          chn_d, chn_q;
    logic [MST_ID_W-1:0]    arid_d, arid_q, awid_d, awid_q;
    logic [SRC_ADDR_W-1:0]  araddr_d, araddr_q;
    logic [DST_ADDR_W-1:0]  awaddr_d, awaddr_q;
    logic [ATX_LEN_W-1:0]   arlen_d, arlen_q, awlen_d, awlen_q;
    logic [1:0]             arburst_d, arburst_q, awburst_d, awburst_q;

    function automatic logic [CW-1:0] chn_inc(input logic [CW-1:0] c);
        return (c == C_LAST_CHN) ? '0 : c + CW'(1);
    endfunction

    assign elig = bwd_atx_vld & chn_en;

    // Descending scan so the lowest offset (fixed: index, WRR: distance from ptr) wins.
    always_comb begin
        win_vld  = 1'b0;
        win_idx  = '0;
        scan_idx = '0;
        for (int i = DMA_CHN_NUM - 1; i >= 0; i--) begin
            if (arb_mode) begin
                scan_idx = (CW+1)'(i);
            end else begin
                scan_idx = {1'b0, ptr_q} + (CW+1)'(i);
                if (scan_idx >= C_CHN_NUM) begin
                    scan_idx = scan_idx - C_CHN_NUM;
                end
            end
            if (elig[scan_idx[CW-1:0]]) begin
                win_vld = 1'b1;
                win_idx = scan_idx[CW-1:0];
            end
        end
    end

    assign slot_free = ~vld_q | fwd_atx_rdy;
    assign capture   = win_vld & slot_free;

    always_comb begin
        for (int c = 0; c < DMA_CHN_NUM; c++) begin
            bwd_atx_rdy[c] = capture && (win_idx == CW'(c));
        end
    end

    // Zero weights behave as one.
    always_comb begin
        rate_ptr = chn_arb_rate[int'(ptr_q)*RW +: RW];
        rate_win = chn_arb_rate[int'(win_idx)*RW +: RW];
        if (rate_ptr == '0) rate_ptr = C_ONE;
        if (rate_win == '0) rate_win = C_ONE;
        ecred = (cred_q == '0) ? rate_ptr : cred_q;
    end

    always_comb begin
        ptr_d  = ptr_q;
        cred_d = cred_q;
        if (capture && !arb_mode) begin
            if (win_idx == ptr_q) begin
                if (ecred > C_ONE) begin
                    cred_d = ecred - C_ONE;
                end else begin
                    ptr_d  = chn_inc(ptr_q);
                    cred_d = '0;
                end
            end else if (rate_win > C_ONE) begin
                ptr_d  = win_idx;
                cred_d = rate_win - C_ONE;
            end else begin
                ptr_d  = chn_inc(win_idx);
                cred_d = '0;
            end
        end
    end

    always_comb begin
        vld_d     = capture | (vld_q & ~fwd_atx_rdy);
        chn_d     = chn_q;
        arid_d    = arid_q;
        araddr_d  = araddr_q;
        arlen_d   = arlen_q;
        arburst_d = arburst_q;
        awid_d    = awid_q;
        awaddr_d  = awaddr_q;
        awlen_d   = awlen_q;
        awburst_d = awburst_q;
        if (capture) begin
            chn_d     = win_idx;
            arid_d    = bwd_arid[int'(win_idx)*MST_ID_W +: MST_ID_W];
            araddr_d  = bwd_araddr[int'(win_idx)*SRC_ADDR_W +: SRC_ADDR_W];
            arlen_d   = bwd_arlen[int'(win_idx)*ATX_LEN_W +: ATX_LEN_W];
            arburst_d = bwd_arburst[int'(win_idx)*2 +: 2];
            awid_d    = bwd_awid[int'(win_idx)*MST_ID_W +: MST_ID_W];
            awaddr_d  = bwd_awaddr[int'(win_idx)*DST_ADDR_W +: DST_ADDR_W];
            awlen_d   = bwd_awlen[int'(win_idx)*ATX_LEN_W +: ATX_LEN_W];
            awburst_d = bwd_awburst[int'(win_idx)*2 +: 2];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q     <= '0;
            cred_q    <= '0;
            vld_q     <= 1'b0;
            chn_q     <= '0;
            arid_q    <= '0;
            araddr_q  <= '0;
            arlen_q   <= '0;
            arburst_q <= '0;
            awid_q    <= '0;
            awaddr_q  <= '0;
            awlen_q   <= '0;
            awburst_q <= '0;
        end else begin
            ptr_q     <= ptr_d;
            cred_q    <= cred_d;
            vld_q     <= vld_d;
            chn_q     <= chn_d;
            arid_q    <= arid_d;
            araddr_q  <= araddr_d;
            arlen_q   <= arlen_d;
            arburst_q <= arburst_d;
            awid_q    <= awid_d;
            awaddr_q  <= awaddr_d;
            awlen_q   <= awlen_d;
            awburst_q <= awburst_d;
        end
    end

    assign fwd_atx_vld    = vld_q;
    assign fwd_atx_chn_id = chn_q;
    assign fwd_arid       = arid_q;
    assign fwd_araddr     = araddr_q;
    assign fwd_arlen      = arlen_q;
    assign fwd_arburst    = arburst_q;
    assign fwd_awid       = awid_q;
    assign fwd_awaddr     = awaddr_q;
    assign fwd_awlen      = awlen_q;
    assign fwd_awburst    = awburst_q;

endmodule
`default_nettype wire

// File: tb/tb_adma_atx_arb_pipe.sv
`default_nettype none
// ============================================================================
// Module  : tb_adma_atx_arb_pipe
// Brief   : Vector table, directed corner sequences and random traffic against
//           a transaction-level model of the arbiter.
// Revision: 1.0
// ============================================================================
module tb_adma_atx_arb_pipe;

    localparam int N  = 4;
    localparam int AW = 3;
    localparam int SA = 32;
    localparam int DA = 32;
    localparam int IW = 5;
    localparam int LW = 8;
    localparam int CW = 2;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [N*IW-1:0]   bwd_arid = '0, bwd_awid = '0;
    logic [N*SA-1:0]   bwd_araddr = '0;
    logic [N*DA-1:0]   bwd_awaddr = '0;
    logic [N*LW-1:0]   bwd_arlen = '0, bwd_awlen = '0;
    logic [N*2-1:0]    bwd_arburst = '0, bwd_awburst = '0;
    logic [N-1:0]      bwd_atx_vld = '0;
    logic [N-1:0]      bwd_atx_rdy;
    logic [N-1:0]      chn_en = '0;
    logic [N*AW-1:0]   chn_arb_rate = '0;
    logic              arb_mode = 1'b0;
    logic [CW-1:0]     fwd_atx_chn_id;
    logic [IW-1:0]     fwd_arid, fwd_awid;
    logic [SA-1:0]     fwd_araddr;
    logic [DA-1:0]     fwd_awaddr;
    logic [LW-1:0]     fwd_arlen, fwd_awlen;
    logic [1:0]        fwd_arburst, fwd_awburst;
    logic              fwd_atx_vld;
    logic              fwd_atx_rdy = 1'b0;

    adma_atx_arb_pipe #(
        .DMA_CHN_NUM(N), .DMA_CHN_ARB_W(AW), .SRC_ADDR_W(SA),
        .DST_ADDR_W(DA), .MST_ID_W(IW), .ATX_LEN_W(LW)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .bwd_arid(bwd_arid), .bwd_araddr(bwd_araddr), .bwd_arlen(bwd_arlen),
        .bwd_arburst(bwd_arburst), .bwd_awid(bwd_awid), .bwd_awaddr(bwd_awaddr),
        .bwd_awlen(bwd_awlen), .bwd_awburst(bwd_awburst),
        .bwd_atx_vld(bwd_atx_vld), .bwd_atx_rdy(bwd_atx_rdy),
        .chn_en(chn_en), .chn_arb_rate(chn_arb_rate), .arb_mode(arb_mode),
        .fwd_atx_chn_id(fwd_atx_chn_id),
        .fwd_arid(fwd_arid), .fwd_araddr(fwd_araddr), .fwd_arlen(fwd_arlen),
        .fwd_arburst(fwd_arburst), .fwd_awid(fwd_awid), .fwd_awaddr(fwd_awaddr),
        .fwd_awlen(fwd_awlen), .fwd_awburst(fwd_awburst),
        .fwd_atx_vld(fwd_atx_vld), .fwd_atx_rdy(fwd_atx_rdy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: arbitration pointer/credit plus the contents of the slot.
    int          m_ptr, m_cred;
    bit          m_vld;
    logic [CW-1:0] m_chn;
    logic [IW-1:0] m_arid, m_awid;
    logic [SA-1:0] m_araddr;
    logic [DA-1:0] m_awaddr;
    logic [LW-1:0] m_arlen, m_awlen;
    logic [1:0]    m_arburst, m_awburst;

    typedef struct {
        bit              rst_before;
        logic [N-1:0]    vld;
        logic [N-1:0]    en;
        logic            mode;
        logic            frdy;
        logic [N*AW-1:0] rate;
        logic [N-1:0]    exp_rdy;
        logic            exp_vld;
        logic [CW-1:0]   exp_chn;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int weight(input int c);
        int w;
        w = int'(chn_arb_rate[c*AW +: AW]);
        return (w == 0) ? 1 : w;
    endfunction

    function automatic int pick(input logic [N-1:0] el, input logic mode, input int p);
        for (int i = 0; i < N; i++) begin
            int c;
            c = mode ? i : (p + i) % N;
            if (el[c]) return c;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_ptr = 0; m_cred = 0; m_vld = 0; m_chn = '0;
        m_arid = '0; m_awid = '0; m_araddr = '0; m_awaddr = '0;
        m_arlen = '0; m_awlen = '0; m_arburst = '0; m_awburst = '0;
    endtask

    task automatic rand_data();
        bwd_arid    = (N*IW)'($urandom);
        bwd_awid    = (N*IW)'($urandom);
        bwd_araddr  = {$urandom, $urandom, $urandom, $urandom};
        bwd_awaddr  = {$urandom, $urandom, $urandom, $urandom};
        bwd_arlen   = $urandom;
        bwd_awlen   = $urandom;
        bwd_arburst = (N*2)'($urandom);
        bwd_awburst = (N*2)'($urandom);
    endtask

    // One clock: check ready mid-cycle, advance the model at the edge, check the slot after it.
    task automatic step(input bit tchk, input logic [N-1:0] t_rdy);
        int w;
        bit cap;
        logic [N-1:0] erdy;
        @(negedge clk);
        w    = pick(bwd_atx_vld & chn_en, arb_mode, m_ptr);
        cap  = (w >= 0) && (!m_vld || fwd_atx_rdy);
        erdy = cap ? N'(1 << w) : '0;
        chk("bwd_atx_rdy", bwd_atx_rdy, erdy);
        if (tchk) chk("tbl_bwd_atx_rdy", bwd_atx_rdy, t_rdy);
        @(posedge clk);
        if (cap) begin
            if (!arb_mode) begin
                int ec;
                ec = (m_cred == 0) ? weight(m_ptr) : m_cred;
                if (w == m_ptr) begin
                    if (ec > 1) m_cred = ec - 1;
                    else begin m_ptr = (m_ptr + 1) % N; m_cred = 0; end
                end else if (weight(w) > 1) begin
                    m_ptr = w; m_cred = weight(w) - 1;
                end else begin
                    m_ptr = (w + 1) % N; m_cred = 0;
                end
            end
            m_vld     = 1;
            m_chn     = CW'(w);
            m_arid    = bwd_arid[w*IW +: IW];
            m_awid    = bwd_awid[w*IW +: IW];
            m_araddr  = bwd_araddr[w*SA +: SA];
            m_awaddr  = bwd_awaddr[w*DA +: DA];
            m_arlen   = bwd_arlen[w*LW +: LW];
            m_awlen   = bwd_awlen[w*LW +: LW];
            m_arburst = bwd_arburst[w*2 +: 2];
            m_awburst = bwd_awburst[w*2 +: 2];
        end else if (fwd_atx_rdy) begin
            m_vld = 0;
        end
        #1;
        chk("fwd_atx_vld", fwd_atx_vld, m_vld);
        chk("fwd_atx_chn_id", fwd_atx_chn_id, m_chn);
        chk("fwd_arid", fwd_arid, m_arid);
        chk("fwd_awid", fwd_awid, m_awid);
        chk("fwd_araddr", fwd_araddr, m_araddr);
        chk("fwd_awaddr", fwd_awaddr, m_awaddr);
        chk("fwd_arlen", fwd_arlen, m_arlen);
        chk("fwd_awlen", fwd_awlen, m_awlen);
        chk("fwd_arburst", fwd_arburst, m_arburst);
        chk("fwd_awburst", fwd_awburst, m_awburst);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_fwd_atx_vld", fwd_atx_vld, 1'b0);
        chk("rst_fwd_atx_chn_id", fwd_atx_chn_id, '0);
        chk("rst_fwd_araddr", fwd_araddr, '0);
        chk("rst_fwd_awaddr", fwd_awaddr, '0);
        chk("rst_fwd_arid", fwd_arid, '0);
        rst_n = 1'b1;
        model_reset();
    endtask

    function automatic vec_t mk(input bit rb, input logic [N-1:0] v, input logic [N-1:0] e,
                                input logic md, input logic fr, input logic [N*AW-1:0] rt,
                                input logic [N-1:0] er, input logic [CW-1:0] ec);
        vec_t t;
        t.rst_before = rb; t.vld = v; t.en = e; t.mode = md; t.frdy = fr; t.rate = rt;
        t.exp_rdy = er; t.exp_vld = 1'b1; t.exp_chn = ec;
        return t;
    endfunction

    initial begin
        logic [N*AW-1:0] r1111, r3121, r0w2;
        r1111 = {3'd1, 3'd1, 3'd1, 3'd1};
        r3121 = {3'd1, 3'd2, 3'd1, 3'd3};
        r0w2  = {3'd1, 3'd0, 3'd1, 3'd1};

        // Plain round robin.
        tbl.push_back(mk(1, 4'b1111, 4'b1111, 0, 1, r1111, 4'b0001, 2'd0));
        tbl.push_back(mk(0, 4'b1111, 4'b1111, 0, 1, r1111, 4'b0010, 2'd1));
        tbl.push_back(mk(0, 4'b1111, 4'b1111, 0, 1, r1111, 4'b0100, 2'd2));
        tbl.push_back(mk(0, 4'b1111, 4'b1111, 0, 1, r1111, 4'b1000, 2'd3));
        tbl.push_back(mk(0, 4'b1111, 4'b1111, 0, 1, r1111, 4'b0001, 2'd0));
        // Weights {3,1,2,1}: 0,0,0,1,2,2,3,0.
        tbl.push_back(mk(1, 4'b1111, 4'b1111, 0, 1, r3121, 4'b0001, 2'd0));
        tbl.push_back(mk(0, 4'b1111, 4'b1111, 0, 1, r3121, 4'b0001, 2'd0));
        tbl.push_back(mk(0, 4'b1111, 4'b1111, 0, 1, r3121, 4'b0001, 2'd0));
        tbl.push_back(mk(0, 4'b1111, 4'b1111, 0, 1, r3121, 4'b0010, 2'd1));
        tbl.push_back(mk(0, 4'b1111, 4'b1111, 0, 1, r3121, 4'b0100, 2'd2));
        tbl.push_back(mk(0, 4'b1111, 4'b1111, 0, 1, r3121, 4'b0100, 2'd2));
        tbl.push_back(mk(0, 4'b1111, 4'b1111, 0, 1, r3121, 4'b1000, 2'd3));
        tbl.push_back(mk(0, 4'b1111, 4'b1111, 0, 1, r3121, 4'b0001, 2'd0));
        // Fixed priority with enable mask.
        tbl.push_back(mk(1, 4'b1010, 4'b1101, 1, 1, r1111, 4'b1000, 2'd3));
        tbl.push_back(mk(0, 4'b1010, 4'b1101, 1, 1, r1111, 4'b1000, 2'd3));
        tbl.push_back(mk(0, 4'b1010, 4'b1111, 1, 1, r1111, 4'b0010, 2'd1));
        tbl.push_back(mk(0, 4'b1010, 4'b1111, 1, 1, r1111, 4'b0010, 2'd1));
        // Zero weight on channel 2: ptr lands on 3 after each grant.
        tbl.push_back(mk(1, 4'b0100, 4'b1111, 0, 1, r0w2, 4'b0100, 2'd2));
        tbl.push_back(mk(0, 4'b0100, 4'b1111, 0, 1, r0w2, 4'b0100, 2'd2));
        tbl.push_back(mk(0, 4'b0100, 4'b1111, 0, 1, r0w2, 4'b0100, 2'd2));
        tbl.push_back(mk(0, 4'b1111, 4'b1111, 0, 1, r0w2, 4'b1000, 2'd3));
        tbl.push_back(mk(0, 4'b1111, 4'b1111, 0, 1, r0w2, 4'b0001, 2'd0));

        model_reset();
        foreach (tbl[i]) begin
            if (tbl[i].rst_before) do_reset();
            bwd_atx_vld  = tbl[i].vld;
            chn_en       = tbl[i].en;
            arb_mode     = tbl[i].mode;
            fwd_atx_rdy  = tbl[i].frdy;
            chn_arb_rate = tbl[i].rate;
            rand_data();
            step(1'b1, tbl[i].exp_rdy);
            chk("tbl_fwd_atx_vld", fwd_atx_vld, tbl[i].exp_vld);
            chk("tbl_fwd_atx_chn_id", fwd_atx_chn_id, tbl[i].exp_chn);
        end

        // Stall for 5 cycles, then drain and refill in one cycle.
        do_reset();
        bwd_atx_vld = 4'b1111; chn_en = 4'b1111; arb_mode = 1'b0;
        chn_arb_rate = r1111; fwd_atx_rdy = 1'b1;
        rand_data();
        step(1'b1, 4'b0001);
        fwd_atx_rdy = 1'b0;
        for (int k = 0; k < 5; k++) begin
            rand_data();
            step(1'b1, 4'b0000);
            chk("stall_fwd_atx_vld", fwd_atx_vld, 1'b1);
            chk("stall_fwd_atx_chn_id", fwd_atx_chn_id, 2'd0);
        end
        fwd_atx_rdy = 1'b1;
        rand_data();
        step(1'b1, 4'b0010);
        chk("refill_fwd_atx_vld", fwd_atx_vld, 1'b1);
        chk("refill_fwd_atx_chn_id", fwd_atx_chn_id, 2'd1);

        // Reset while full and stalled: valid drops without waiting for a clock.
        fwd_atx_rdy = 1'b0;
        step(1'b1, 4'b0000);
        rst_n = 1'b0;
        #1;
        chk("async_rst_fwd_atx_vld", fwd_atx_vld, 1'b0);
        do_reset();
        fwd_atx_rdy = 1'b1;
        rand_data();
        step(1'b1, 4'b0001);
        chk("post_rst_fwd_atx_chn_id", fwd_atx_chn_id, 2'd0);

        // Random traffic against the model.
        do_reset();
        for (int k = 0; k < 600; k++) begin
            bwd_atx_vld = N'($urandom);
            chn_en      = N'($urandom) | N'($urandom);
            fwd_atx_rdy = ($urandom_range(0, 9) < 7);
            if ($urandom_range(0, 19) == 0) arb_mode = ~arb_mode;
            if ($urandom_range(0, 9) == 0) chn_arb_rate = (N*AW)'($urandom);
            rand_data();
            step(1'b0, '0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/adma_atx_arb_pipe.md
Name: adma_atx_arb_pipe

Overview:
N-channel AXI transaction-descriptor arbiter for the ADMA AXI-stream side. Each DMA channel offers a paired AR/AW transaction. The block picks one using credit-based weighted round-robin or fixed priority, gated by a per-channel enable mask. The winner is placed in a fully registered output slot toward the AXI master issue logic. It replaces the combinational grant path with a 1-cycle pipelined, back-pressure-safe stage.

Parameters:
DMA_CHN_NUM, 4, number of DMA channels (>=2)
DMA_CHN_ARB_W, 3, per-channel weight width
SRC_ADDR_W, 32, AR address width
DST_ADDR_W, 32, AW address width
MST_ID_W, 5, AXI ID width
ATX_LEN_W, 8, AXI burst length width
DMA_CHN_NUM_W, $clog2(DMA_CHN_NUM), channel index width (derived, not configured)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
bwd_arid/bwd_awid  in  N*MST_ID_W  per-channel IDs, channel c at slice [(c+1)*W-1 -: W]
bwd_araddr  in  N*SRC_ADDR_W  per-channel read address
bwd_awaddr  in  N*DST_ADDR_W  per-channel write address
bwd_arlen/bwd_awlen  in  N*ATX_LEN_W  per-channel burst lengths
bwd_arburst/bwd_awburst  in  N*2  per-channel burst types
bwd_atx_vld  in  N  per-channel request valid
bwd_atx_rdy  out  N  per-channel accept, one-hot or zero
chn_en  in  N  channel enable mask; disabled channels are never granted
chn_arb_rate  in  N*DMA_CHN_ARB_W  per-channel weight; 0 is treated as 1
arb_mode  in  1  0 = weighted round-robin (WRR), 1 = fixed priority (channel 0 highest)
fwd_atx_chn_id  out  DMA_CHN_NUM_W  registered channel index of the held transaction
fwd_arid, fwd_araddr, fwd_arlen, fwd_arburst, fwd_awid, fwd_awaddr, fwd_awlen, fwd_awburst  out  matching widths  registered transaction fields
fwd_atx_vld  out  1  output slot valid
fwd_atx_rdy  in  1  downstream accept

Behaviour:
- Reset (async assert, sync release):
  - fwd_atx_vld = 0; all fwd_* data and fwd_atx_chn_id = 0.
  - ptr = 0; cred = 0.
- Eligibility: elig[c] = bwd_atx_vld[c] & chn_en[c].
- Winner w, combinational:
  - mode 1: lowest-index eligible channel.
  - mode 0: first eligible channel scanning ptr, ptr+1, ... with wrap mod N.
  - No eligible channel: no winner.
- Slot accept: slot_free = ~fwd_atx_vld | fwd_atx_rdy.
  - bwd_atx_rdy[w] = winner_exists & slot_free; all other bits are 0.
  - bwd_atx_rdy is a function of bwd_atx_vld; upstream must not wait for ready before asserting valid.
- Capture: on bwd handshake, channel w's fields and index load into the slot and fwd_atx_vld <= 1 next cycle. Latency is 1 cycle.
- Drain without refill: fwd handshake with no capture gives fwd_atx_vld <= 0.
- Simultaneous drain and capture: the slot is overwritten with no bubble, sustaining 1 transaction/cycle.
- Output stability: while fwd_atx_vld & ~fwd_atx_rdy, all fwd_* outputs are held stable.
- WRR credit update, on capture only when arb_mode = 0:
  - ecred = (cred == 0) ? max(weight[ptr], 1) : cred.
  - If w == ptr and ecred > 1: cred <= ecred - 1; ptr unchanged.
  - If w == ptr and ecred <= 1: ptr <= (ptr+1) mod N; cred <= 0 (reload on next use).
  - If w != ptr (ptr channel idle or disabled): if max(weight[w], 1) > 1 then ptr <= w, cred <= weight[w] - 1; else ptr <= (w+1) mod N, cred <= 0.
- Fixed-priority captures leave ptr and cred unchanged.
- A change to arb_mode, chn_en or chn_arb_rate takes effect at the next arbitration. It never alters a transaction already in the slot.
- A channel dropping bwd_atx_vld before handshake is legal; the winner re-evaluates that cycle.
- N not a power of two: ptr wraps at N-1 -> 0. Indices >= N are never produced.
- Reset asserted mid-operation discards the held transaction; fwd_atx_vld drops immediately.

Test Plan:
- Reset, then all 4 channels valid, weights {1,1,1,1}, mode 0, fwd_atx_rdy = 1 -> grants 0,1,2,3,0,... one per cycle; first fwd_atx_vld one cycle after the first bwd_atx_rdy.
- Weights {3,1,2,1}, all valid, mode 0 -> fwd_atx_chn_id sequence 0,0,0,1,2,2,3, repeating.
- fwd_atx_rdy = 0 for 5 cycles with slot full -> fwd_* stable, bwd_atx_rdy = 0; rdy = 1 -> drain and refill in the same cycle, no bubble.
- Mode 1, channels 1 and 3 valid, chn_en = 4'b1101 -> only channel 3 granted; then chn_en = 4'b1111 -> channel 1 wins every cycle.
- Weight 0 on channel 2, mode 0, only channel 2 valid -> granted every cycle; weight treated as 1, ptr advances to 3 after each grant.
- Reset asserted while slot is full and stalled -> fwd_atx_vld = 0 immediately; first grant after release is channel 0 when all are valid.
